// File: rtl/legv8_pkg.sv
// Shared constants, the native LEGv8 fetch-entry layout and a width helper
// for the instruction-fetch front end.
package legv8_pkg;

   localparam int INSTR_BYTES = 4;

   // Queue entries are packed {pc, instr}, matching this layout at native widths.
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fetch_queue_legv8_if.sv
// Fetch front-end bus: instruction ROM port, redirect input and the
// instruction stream toward the control unit.
interface fetch_queue_legv8_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 3
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic [ADDR_W-1:0]  out_pc4;
   logic [CNT_W-1:0]   count;

   // Handshake: a head entry transfers at the rising edge where out_valid and
   // out_ready are both high; out_valid never depends on out_ready, and while
   // out_valid is high the head fields hold until accepted or flushed by redirect.
   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4, count,
      input  imem_data, redirect, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4, count,
      output imem_data, redirect, redirect_pc, out_ready
   );
endinterface

// File: rtl/fifo_sync_legv8.sv
// Synchronous circular FIFO with flush; flush wins over push and pop.
module fifo_sync_legv8
   import legv8_pkg::*;
#(
   parameter int WIDTH = 96,
   parameter int DEPTH = 4,
   localparam int PTR_W = clog2(DEPTH),
   localparam int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue_legv8.sv
// LEGv8 fetch front end: PC, one-deep in-flight ROM tracking, credit-based
// issue and a decoupling queue. FETCH_QUEUE_BYPASS_EN enables empty-queue bypass.
module fetch_queue_legv8
   import legv8_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter int                INSTR_W  = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic               clock,
   input logic               reset,
   fetch_queue_legv8_if.master bus
);
   localparam int                CNT_W      = clog2(DEPTH + 1);
   localparam int                ENTRY_W    = ADDR_W + INSTR_W;
   localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  inflight_pc;
   logic               inflight;
   logic               issue;
   logic               ret_valid;
   logic               q_push;
   logic               q_pop;
   logic               q_empty;
   logic [CNT_W-1:0]   q_count;
   logic [ENTRY_W-1:0] q_head;
   logic               head_valid;
   logic [ADDR_W-1:0]  head_pc;
   logic [INSTR_W-1:0] head_instr;

   // Credit counts the in-flight fetch so a returning word always has a free slot.
   assign issue = !reset && !bus.redirect &&
                  (({1'b0, q_count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_C);
   assign ret_valid = inflight && !bus.redirect;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC & ALIGN_MASK;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (bus.redirect) begin
         fetch_pc <= bus.redirect_pc & ALIGN_MASK;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + STEP;
         end
      end
   end

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;
   assign bypass     = q_empty && ret_valid;
   assign head_valid = !q_empty || ret_valid;
   assign head_pc    = bypass ? inflight_pc   : q_head[ENTRY_W-1 -: ADDR_W];
   assign head_instr = bypass ? bus.imem_data : q_head[INSTR_W-1:0];
   // A bypassed word consumed in its arrival cycle never enters the queue.
   assign q_push     = ret_valid && !(q_empty && bus.out_ready);
   assign q_pop      = !q_empty && bus.out_ready;
`else
   assign head_valid = !q_empty;
   assign head_pc    = q_head[ENTRY_W-1 -: ADDR_W];
   assign head_instr = q_head[INSTR_W-1:0];
   assign q_push     = ret_valid;
   assign q_pop      = head_valid && bus.out_ready;
`endif

   fifo_sync_legv8 #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (bus.redirect),
      .push  (q_push),
      .pop   (q_pop),
      .din   ({inflight_pc, bus.imem_data}),
      .dout  (q_head),
      .count (q_count),
      .empty (q_empty)
   );

   assign bus.imem_req  = issue;
   assign bus.imem_addr = fetch_pc;
   assign bus.out_valid = head_valid;
   assign bus.out_pc    = head_valid ? head_pc : '0;
   assign bus.out_instr = head_valid ? head_instr : '0;
   assign bus.out_pc4   = head_valid ? head_pc + STEP : '0;
   assign bus.count     = q_count;

endmodule

// File: tb/tb_fetch_queue_legv8.sv
// Directed bench for fetch_queue_legv8 with a one-cycle-latency ROM model.
module tb_fetch_queue_legv8;
   import legv8_pkg::*;

   localparam int ADDR_W  = 64;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [INSTR_W-1:0] rom_q = '0;
   int                 vectors = 0;
   int                 miscompares = 0;
   logic [ADDR_W-1:0]  exp_q[$];

   fetch_queue_legv8_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

   fetch_queue_legv8 #(
      .ADDR_W   (ADDR_W),
      .INSTR_W  (INSTR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (64'h0)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [INSTR_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h8B00_0000;
   endfunction

   always @(posedge clock) begin
      if (bus.imem_req === 1'b1) rom_q <= rom_f(bus.imem_addr);
      else                       rom_q <= 32'hDEAD_BEEF;
   end
   assign bus.imem_data = rom_q;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready = 1'b1;
      step();
      vectors++;
      if ({bus.out_valid, bus.count, bus.imem_req} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got valid=%b count=%0d req=%b, want 0 0 0",
                  bus.out_valid, bus.count, bus.imem_req);
      end
      vectors++;
      if (bus.out_pc !== '0 || bus.out_instr !== '0 || bus.out_pc4 !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got pc=%h instr=%h pc4=%h, want all 0",
                  bus.out_pc, bus.out_instr, bus.out_pc4);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin
         miscompares++;
         $display("FAIL first_issue: got req=%b addr=%h, want 1 0", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_stream();
      logic [ADDR_W-1:0] exp_pc;
      do_reset();
      bus.out_ready = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== ADDR_W'(4 * k)) begin
            miscompares++;
            $display("FAIL stream_addr[%0d]: got req=%b addr=%h, want 1 %h",
                     k, bus.imem_req, bus.imem_addr, ADDR_W'(4 * k));
         end
         if (k >= LAT) begin
            exp_pc = ADDR_W'(4 * (k - LAT));
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc ||
                bus.out_pc4 !== exp_pc + ADDR_W'(4) || bus.out_instr !== rom_f(exp_pc)) begin
               miscompares++;
               $display("FAIL stream_out[%0d]: got v=%b pc=%h pc4=%h instr=%h, want 1 %h %h %h",
                        k, bus.out_valid, bus.out_pc, bus.out_pc4, bus.out_instr,
                        exp_pc, exp_pc + ADDR_W'(4), rom_f(exp_pc));
            end
         end else begin
            vectors++;
            if (bus.out_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL stream_latency[%0d]: got valid=%b, want 0", k, bus.out_valid);
            end
         end
         step();
      end
   endtask

   task automatic test_stall();
      int issues;
      logic [ADDR_W-1:0] exp_pc;
      do_reset();
      issues = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.imem_req === 1'b1) issues++;
         step();
      end
      vectors++;
      if (issues != DEPTH || bus.count !== CNT_W'(DEPTH)) begin
         miscompares++;
         $display("FAIL stall_credit: got issues=%0d count=%0d, want %0d %0d",
                  issues, bus.count, DEPTH, DEPTH);
      end
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin
         miscompares++;
         $display("FAIL stall_head: got v=%b pc=%h, want 1 0", bus.out_valid, bus.out_pc);
      end
      exp_q.delete();
      for (int i = 0; i < 5; i++) exp_q.push_back(ADDR_W'(4 * i));
      bus.out_ready = 1'b1;
      #1;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
         if (bus.out_valid === 1'b1) begin
            exp_pc = exp_q.pop_front();
            vectors++;
            if (bus.out_pc !== exp_pc || bus.out_instr !== rom_f(exp_pc)) begin
               miscompares++;
               $display("FAIL stall_drain: got pc=%h instr=%h, want %h %h",
                        bus.out_pc, bus.out_instr, exp_pc, rom_f(exp_pc));
            end
         end
         step();
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL stall_timeout: got %0d pops outstanding, want 0", exp_q.size());
      end
   endtask

   task automatic test_redirect();
      int n;
      do_reset();
      repeat (4) step();
      vectors++;
      if (bus.count !== CNT_W'(3)) begin
         miscompares++;
         $display("FAIL redir_setup: got count=%0d, want 3", bus.count);
      end
      bus.redirect = 1'b1;
      bus.redirect_pc = 64'h105;
      step();
      bus.redirect = 1'b0;
      #1;
      vectors++;
      if (bus.count !== '0 || bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
          bus.imem_addr !== 64'h104) begin
         miscompares++;
         $display("FAIL redir_flush: got count=%0d v=%b req=%b addr=%h, want 0 0 1 104",
                  bus.count, bus.out_valid, bus.imem_req, bus.imem_addr);
      end
      bus.out_ready = 1'b1;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      vectors++;
      if (n != LAT || bus.out_pc !== 64'h104 || bus.out_instr !== rom_f(64'h104)) begin
         miscompares++;
         $display("FAIL redir_target: got wait=%0d pc=%h instr=%h, want %0d 104 %h",
                  n, bus.out_pc, bus.out_instr, LAT, rom_f(64'h104));
      end
   endtask

   task automatic test_redirect_pop();
      int n;
      do_reset();
      bus.out_ready = 1'b1;
      repeat (5) step();
      bus.redirect = 1'b1;
      bus.redirect_pc = 64'h200;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== ADDR_W'(4 * (5 - LAT)) || bus.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL rpop_cycle: got v=%b pc=%h req=%b, want 1 %h 0",
                  bus.out_valid, bus.out_pc, bus.imem_req, ADDR_W'(4 * (5 - LAT)));
      end
      step();
      bus.redirect = 1'b0;
      #1;
      vectors++;
      if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rpop_empty: got count=%0d v=%b, want 0 0", bus.count, bus.out_valid);
      end
      step();
      vectors++;
      if (bus.count !== '0 || bus.out_valid !== (LAT == 1)) begin
         miscompares++;
         $display("FAIL rpop_stale: got count=%0d v=%b, want 0 %b", bus.count, bus.out_valid, LAT == 1);
      end
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      vectors++;
      if (bus.out_pc !== 64'h200) begin
         miscompares++;
         $display("FAIL rpop_target: got pc=%h, want 200", bus.out_pc);
      end
   endtask

   task automatic test_wrap();
      int n;
      do_reset();
      bus.out_ready = 1'b1;
      repeat (3) step();
      bus.redirect = 1'b1;
      bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      bus.redirect = 1'b0;
      #1;
      vectors++;
      if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         miscompares++;
         $display("FAIL wrap_addr0: got %h, want fffffffffffffffc", bus.imem_addr);
      end
      step();
      vectors++;
      if (bus.imem_addr !== 64'h0) begin
         miscompares++;
         $display("FAIL wrap_addr1: got %h, want 0", bus.imem_addr);
      end
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      vectors++;
      if (bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.out_pc4 !== 64'h0) begin
         miscompares++;
         $display("FAIL wrap_pc4: got pc=%h pc4=%h, want fffffffffffffffc 0", bus.out_pc, bus.out_pc4);
      end
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_pc4 !== 64'h4) begin
         miscompares++;
         $display("FAIL wrap_next: got v=%b pc=%h pc4=%h, want 1 0 4",
                  bus.out_valid, bus.out_pc, bus.out_pc4);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      repeat (3) step();
      vectors++;
      if (bus.count !== CNT_W'(2)) begin
         miscompares++;
         $display("FAIL rmid_setup: got count=%0d, want 2", bus.count);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.count !== '0 || bus.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_async: got v=%b count=%0d req=%b, want 0 0 0",
                  bus.out_valid, bus.count, bus.imem_req);
      end
      step();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      vectors++;
      if (bus.imem_addr !== 64'h0 || bus.imem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL rmid_refetch: got req=%b addr=%h, want 1 0", bus.imem_req, bus.imem_addr);
      end
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      vectors++;
      if (n != LAT || bus.out_pc !== 64'h0) begin
         miscompares++;
         $display("FAIL rmid_first: got wait=%0d pc=%h, want %0d 0", n, bus.out_pc, LAT);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "simulation did not complete");
   end

   initial begin
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_pop();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
